delayed_operand_resolver: RTL and testbench
===========================================

// Module: delayed_operand_resolver
// PURPOSE
//  Parametrised multi-lane successor of the delayed-operand forward stage. Sits between exec and dcache.
//  - Re-reads the regfile for each lane's rs1/rs2 and forwards from NUM_SRC later-pipeline producers.
//  - Stalls while any matching producer's data is not yet ready (e.g. load in flight).
//  - Registers the resolved operands.
//  - Resolves lane-0 branches early and flags mispredicts.
// PARAMETERS
//  LANES     2   issue lanes resolved per bundle
//  NUM_SRC   6   forwarding producers; index 0 = youngest = highest priority
//  DW        32  data width
//  RW        5   register address width
//  CNT_W     16  stall counter width
// PORTS
//  clk              in   1             clock
//  rst_n            in   1             synchronous reset, active low
//  flush            in   1             discard held/captured bundle
//  in_valid         in   1             bundle offered
//  in_ready         out  1             bundle accepted when in_valid&in_ready
//  in_rs1/in_rs2    in   LANES*RW      source register addresses
//  in_use_imm       in   LANES         op2 takes in_imm instead of rs2
//  in_imm           in   LANES*DW      immediate operand
//  in_br_op         in   3             lane0: 0 none,1 EQ,2 NE,3 LTZ,4 GEZ,5 LEZ,6 GTZ,7 JR
//  in_br_target     in   DW            lane0 precomputed PC-relative target
//  in_pred_taken    in   1             lane0 predicted direction
//  in_pred_target   in   DW            lane0 predicted target
//  rf_raddr         out  LANES*2*RW    regfile read addresses (from captured bundle)
//  rf_rdata         in   LANES*2*DW    regfile data, same cycle as rf_raddr
//  src_valid        in   NUM_SRC       producer slot holds a register-writing instr
//  src_rd           in   NUM_SRC*RW    producer destination
//  src_rdy          in   NUM_SRC       producer data available
//  src_wdata        in   NUM_SRC*DW    producer data
//  out_valid        out  1             resolved bundle available
//  out_ready        in   1             consumer accepts
//  out_op1/out_op2  out  LANES*DW      resolved operands
//  br_valid         out  1             lane0 branch outcome valid, aligned with out_valid
//  br_taken         out  1             branch condition result
//  br_target        out  DW            rs1 for JR, else in_br_target
//  br_mispredict    out  1             br_taken!=pred_taken, or taken and target!=pred_target
//  stall_cnt        out  CNT_W         cycles spent in WAIT, saturating
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge):
//    - state=EMPTY; out_valid, br_valid, br_taken, br_mispredict = 0.
//    - out_op*, br_target = 0; stall_cnt = 0.
//  - States:
//    - EMPTY -> CAPT on accept.
//    - CAPT -> FULL when all operands resolvable; else CAPT (counted as WAIT).
//    - FULL -> EMPTY on out_ready & !in_valid.
//    - FULL -> CAPT on out_ready & in_valid.
//  - in_ready = (state==EMPTY) | (state==FULL & out_ready); combinational, 0 while rst_n=0.
//  - Latency: bundle accepted at edge N -> out_valid at edge N+1 if no stall. Throughput 1 bundle / 2 cycles.
//  - Operand resolution, per lane and operand, in the CAPT cycle:
//    - Start from rf_rdata.
//    - Override with the lowest-index src j having src_valid & src_rd==addr.
//    - addr==0 always yields 0 and never matches a producer.
//    - in_use_imm forces op2 = imm; rs2 hazards are then ignored.
//  - Hazard: the winning src has src_rdy=0 -> stay in CAPT, stall_cnt += 1 (saturates at all-ones), re-evaluate next cycle.
//  - No forwarding between lanes of the same bundle (the issue stage guarantees independence).
//  - Branch evaluation uses resolved op1/op2, registered with the operands:
//    - EQ: a==b;  NE: a!=b.
//    - LTZ: a[DW-1].  GEZ: !a[DW-1].
//    - LEZ: a[DW-1] | a==0.  GTZ: !a[DW-1] & a!=0.
//    - JR: taken=1.
//    - br_op=0 -> br_valid=0.
//  - out_* hold stable while out_valid & !out_ready.
//  - flush (priority over everything except reset):
//    - Next state EMPTY; out_valid=0, br_valid=0.
//    - A same-cycle in_valid is dropped.
//    - stall_cnt is kept.
//  - Reset mid-stall: returns to EMPTY; the captured bundle is lost.
// CONFIGURATION
//  DELAYED_FWD_BRANCH_EN
//   defined:   branch evaluation and mispredict logic as above.
//   undefined: br_valid, br_taken, br_mispredict, br_target tied to 0; in_br_*/in_pred_* ignored; no branch logic.
// TESTING
//  1. rs1=3, rf=0x11; src2 valid rd=3 rdy wdata=0x22; src4 valid rd=3 wdata=0x44
//     -> out_op1=0x22 one cycle after accept.
//  2. rs1=0; src0 valid rd=0 wdata=0xFF
//     -> out_op1=0.
//  3. rs2=7; src1 rd=7 rdy=0 for 3 cycles, then rdy=1 wdata=0x5
//     -> out_valid after 3 WAIT cycles, op2=0x5, stall_cnt=3.
//     -> Repeat with use_imm=1, imm=0x9: no stall, op2=0x9.
//  4. BGTZ, op1=0x80000000, pred_taken=1
//     -> br_taken=0, br_mispredict=1.
//     -> JR op1=0x400, pred_target=0x400, pred_taken=1 -> br_target=0x400, br_mispredict=0.
//  5. out_ready=0 for 4 cycles with back-to-back in_valid
//     -> in_ready=0, outputs stable; on out_ready=1 next bundle accepted the same cycle.
//  6. flush during WAIT with in_valid=1 -> EMPTY next cycle, out_valid=0, offered bundle not accepted;
//     rst_n=0 mid-stall -> all outputs reset values.

Source files
------------

// File: rtl/delayed_operand_resolver.sv
`default_nettype none
// ==========================================================================
// delayed_operand_resolver : multi-lane regfile re-read + producer forwarding
//   with hazard stall; lane-0 branch resolve when DELAYED_FWD_BRANCH_EN is set.
// Rev 1.0
// ==========================================================================
module delayed_operand_resolver #(
  parameter int LANES   = 2,
  parameter int NUM_SRC = 6,
  parameter int DW      = 32,
  parameter int RW      = 5,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*RW-1:0]     in_rs1,
  input  logic [LANES*RW-1:0]     in_rs2,
  input  logic [LANES-1:0]        in_use_imm,
  input  logic [LANES*DW-1:0]     in_imm,
  input  logic [2:0]              in_br_op,
  input  logic [DW-1:0]           in_br_target,
  input  logic                    in_pred_taken,
  input  logic [DW-1:0]           in_pred_target,
  output logic [LANES*2*RW-1:0]   rf_raddr,
  input  logic [LANES*2*DW-1:0]   rf_rdata,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [NUM_SRC*RW-1:0]   src_rd,
  input  logic [NUM_SRC-1:0]      src_rdy,
  input  logic [NUM_SRC*DW-1:0]   src_wdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DW-1:0]     out_op1,
  output logic [LANES*DW-1:0]     out_op2,
  output logic                    br_valid,
  output logic                    br_taken,
  output logic [DW-1:0]           br_target,
  output logic                    br_mispredict,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam logic [1:0] c_ST_EMPTY = 2'd0;
  localparam logic [1:0] c_ST_CAPT  = 2'd1;
  localparam logic [1:0] c_ST_FULL  = 2'd2;

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic                    w_accept;
  logic                    w_load_out;
  logic                    w_stall;
  logic                    w_resolved;

  // Captured bundle; operand g of the flat read port is lane g/2, rs1 (even) or rs2 (odd)
  logic [LANES*2*RW-1:0]   r_raddr;
  logic [LANES-1:0]        r_use_imm;
  logic [LANES*DW-1:0]     r_imm;

  logic [LANES*2*DW-1:0]   w_res;
  logic [LANES*2-1:0]      w_haz;
  logic [LANES*DW-1:0]     w_op1;
  logic [LANES*DW-1:0]     w_op2;
  logic [LANES-1:0]        w_lane_haz;

  logic [LANES*DW-1:0]     r_op1;
  logic [LANES*DW-1:0]     r_op2;
  logic [CNT_W-1:0]        r_stall_cnt;

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = c_ST_EMPTY;
    end else begin
      case (r_state)
        c_ST_EMPTY: if (in_valid) w_state_nxt = c_ST_CAPT;
        c_ST_CAPT:  if (w_resolved) w_state_nxt = c_ST_FULL;
        c_ST_FULL:  if (out_ready) w_state_nxt = in_valid ? c_ST_CAPT : c_ST_EMPTY;
        default:    w_state_nxt = c_ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    if (rst_n) in_ready = (r_state == c_ST_EMPTY) || ((r_state == c_ST_FULL) && out_ready);
    out_valid  = (r_state == c_ST_FULL);
    w_accept   = in_valid && in_ready && !flush;
    w_load_out = (r_state == c_ST_CAPT) && w_resolved && !flush;
    w_stall    = (r_state == c_ST_CAPT) && !w_resolved && !flush;
  end

  // ------------------------------------------------------------ capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_raddr   <= '0;
      r_use_imm <= '0;
      r_imm     <= '0;
    end else if (w_accept) begin
      for (int l = 0; l < LANES; l++) begin
        r_raddr[(2*l)*RW   +: RW] <= in_rs1[l*RW +: RW];
        r_raddr[(2*l+1)*RW +: RW] <= in_rs2[l*RW +: RW];
      end
      r_use_imm <= in_use_imm;
      r_imm     <= in_imm;
    end
  end

  assign rf_raddr = r_raddr;

  // ---------------------------------------------------------- resolution
  for (genvar g = 0; g < LANES*2; g++) begin : g_opnd
    logic [RW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          w_wait;

    assign w_addr = r_raddr[g*RW +: RW];

    // Walk oldest to youngest so the lowest matching index ends up winning
    always_comb begin
      w_data = rf_rdata[g*DW +: DW];
      w_wait = 1'b0;
      if (w_addr == '0) begin
        w_data = '0;
      end else begin
        for (int j = NUM_SRC-1; j >= 0; j--) begin
          if (src_valid[j] && (src_rd[j*RW +: RW] == w_addr)) begin
            w_data = src_wdata[j*DW +: DW];
            w_wait = !src_rdy[j];
          end
        end
      end
    end

    assign w_res[g*DW +: DW] = w_data;
    assign w_haz[g]          = w_wait;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_op1[l*DW +: DW] = w_res[(2*l)*DW +: DW];
    assign w_op2[l*DW +: DW] = r_use_imm[l] ? r_imm[l*DW +: DW] : w_res[(2*l+1)*DW +: DW];
    assign w_lane_haz[l]     = w_haz[2*l] || (w_haz[2*l+1] && !r_use_imm[l]);
  end

  assign w_resolved = ~|w_lane_haz;

  // ------------------------------------------------------- output regs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op1       <= '0;
      r_op2       <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_load_out) begin
        r_op1 <= w_op1;
        r_op2 <= w_op2;
      end
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign out_op1   = r_op1;
  assign out_op2   = r_op2;
  assign stall_cnt = r_stall_cnt;

  // ------------------------------------------------------------ branch
`ifdef DELAYED_FWD_BRANCH_EN
  logic [2:0]    r_br_op;
  logic [DW-1:0] r_br_tgt_in;
  logic          r_pred_taken;
  logic [DW-1:0] r_pred_tgt;
  logic          r_br_valid;
  logic          r_br_taken;
  logic [DW-1:0] r_br_target;
  logic          r_br_misp;
  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic [DW-1:0] w_tgt;
  logic          w_cond;
  logic          w_misp;

  assign w_a = w_op1[DW-1:0];
  assign w_b = w_op2[DW-1:0];

  always_comb begin
    w_cond = 1'b0;
    case (r_br_op)
      3'd1:    w_cond = (w_a == w_b);
      3'd2:    w_cond = (w_a != w_b);
      3'd3:    w_cond = w_a[DW-1];
      3'd4:    w_cond = !w_a[DW-1];
      3'd5:    w_cond = w_a[DW-1] || (w_a == '0);
      3'd6:    w_cond = !w_a[DW-1] && (w_a != '0);
      3'd7:    w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
    w_tgt  = (r_br_op == 3'd7) ? w_a : r_br_tgt_in;
    w_misp = (r_br_op != 3'd0) &&
             ((w_cond != r_pred_taken) || (w_cond && (w_tgt != r_pred_tgt)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_br_op      <= '0;
      r_br_tgt_in  <= '0;
      r_pred_taken <= 1'b0;
      r_pred_tgt   <= '0;
      r_br_valid   <= 1'b0;
      r_br_taken   <= 1'b0;
      r_br_target  <= '0;
      r_br_misp    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_br_op      <= in_br_op;
        r_br_tgt_in  <= in_br_target;
        r_pred_taken <= in_pred_taken;
        r_pred_tgt   <= in_pred_target;
      end
      if (w_load_out) begin
        r_br_valid  <= (r_br_op != 3'd0);
        r_br_taken  <= w_cond;
        r_br_target <= w_tgt;
        r_br_misp   <= w_misp;
      end
    end
  end

  assign br_valid      = out_valid && r_br_valid;
  assign br_taken      = r_br_taken;
  assign br_target     = r_br_target;
  assign br_mispredict = r_br_misp;
`else
  logic w_unused_br;
  assign w_unused_br   = ^{in_br_op, in_br_target, in_pred_taken, in_pred_target};
  assign br_valid      = 1'b0;
  assign br_taken      = 1'b0;
  assign br_target     = '0;
  assign br_mispredict = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_delayed_operand_resolver.sv
`default_nettype none
// ==========================================================================
// tb_delayed_operand_resolver : directed self-checking bench. Rev 1.0
// ==========================================================================
module tb_delayed_operand_resolver;

`ifdef DELAYED_FWD_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready, out_ready;
  logic [9:0]   in_rs1, in_rs2;
  logic [1:0]   in_use_imm;
  logic [63:0]  in_imm;
  logic [2:0]   in_br_op;
  logic [31:0]  in_br_target, in_pred_target;
  logic         in_pred_taken;
  logic [19:0]  rf_raddr;
  logic [127:0] rf_rdata;
  logic [5:0]   src_valid, src_rdy;
  logic [29:0]  src_rd;
  logic [191:0] src_wdata;
  logic         out_valid;
  logic [63:0]  out_op1, out_op2;
  logic         br_valid, br_taken, br_mispredict;
  logic [31:0]  br_target;
  logic [15:0]  stall_cnt;

  logic [31:0]  rf [32];
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    rf_rdata = '0;
    for (int g = 0; g < 4; g++) rf_rdata[g*32 +: 32] = rf[rf_raddr[g*5 +: 5]];
  end

  delayed_operand_resolver dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_br_op(in_br_op), .in_br_target(in_br_target), .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .src_valid(src_valid), .src_rd(src_rd), .src_rdy(src_rdy), .src_wdata(src_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .br_mispredict(br_mispredict), .stall_cnt(stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bundle(input logic [4:0] a0, input logic [4:0] b0,
                        input logic [4:0] a1, input logic [4:0] b1);
    in_rs1 = {a1, a0};
    in_rs2 = {b1, b0};
  endtask

  task automatic set_src(input int j, input logic [4:0] rd, input logic rdy, input logic [31:0] wd);
    src_valid[j]        = 1'b1;
    src_rd[j*5 +: 5]    = rd;
    src_rdy[j]          = rdy;
    src_wdata[j*32 +: 32] = wd;
  endtask

  task automatic clr_src();
    src_valid = '0; src_rd = '0; src_rdy = '0; src_wdata = '0;
  endtask

  // Offer the current bundle from EMPTY; returns mid-cycle with the result in FULL
  task automatic issue(input string tag);
    in_valid = 1'b1;
    mid(); chk({tag, "_in_ready"}, in_ready, 1);
    tick(); in_valid = 1'b0;
    mid(); chk({tag, "_capt_no_valid"}, out_valid, 0);
    tick();
    mid(); chk({tag, "_out_valid"}, out_valid, 1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_rs1 = '0; in_rs2 = '0; in_use_imm = '0; in_imm = '0;
    in_br_op = '0; in_br_target = '0; in_pred_taken = 1'b0; in_pred_target = '0;
    clr_src();
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
    rf[0] = 32'hDEAD_0000;
    rf[3] = 32'h11;

    // Reset values
    tick(); tick();
    mid();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_op1", out_op1, 0);
    chk("rst_br_valid", br_valid, 0);
    tick(); rst_n = 1'b1;

    // 1: youngest matching producer wins over older one and over regfile
    bundle(5'd3, 5'd5, 5'd6, 5'd9);
    set_src(2, 5'd3, 1'b1, 32'h22);
    set_src(4, 5'd3, 1'b0, 32'h44);
    set_src(5, 5'd6, 1'b1, 32'h66);
    issue("t1");
    chk("t1_op1", out_op1, {32'h66, 32'h22});
    chk("t1_op2", out_op2, {32'h1000_0009, 32'h1000_0005});
    chk("t1_br_valid", br_valid, 0);
    chk("t1_stall_cnt", stall_cnt, 0);
    tick(); clr_src();

    // 2: r0 reads zero and never matches (even a not-ready producer)
    bundle(5'd0, 5'd0, 5'd4, 5'd3);
    set_src(0, 5'd0, 1'b0, 32'hFF);
    issue("t2");
    chk("t2_op1", out_op1, {32'h1000_0004, 32'h0});
    chk("t2_op2", out_op2, {32'h11, 32'h0});
    tick(); clr_src();

    // 3: not-ready youngest producer stalls even if an older one is ready
    bundle(5'd1, 5'd7, 5'd2, 5'd8);
    set_src(1, 5'd7, 1'b0, 32'hBAD);
    set_src(3, 5'd7, 1'b1, 32'h77);
    in_valid = 1'b1;
    mid(); chk("t3_in_ready", in_ready, 1);
    tick(); in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mid(); chk("t3_wait", out_valid, 0);
      tick();
    end
    set_src(1, 5'd7, 1'b1, 32'h5);
    mid();
    chk("t3_still_wait", out_valid, 0);
    chk("t3_cnt_wait", stall_cnt, 3);
    tick();
    mid();
    chk("t3_out_valid", out_valid, 1);
    chk("t3_op1", out_op1, {32'h1000_0002, 32'h1000_0001});
    chk("t3_op2", out_op2, {32'h1000_0008, 32'h5});
    chk("t3_stall_cnt", stall_cnt, 3);
    tick(); clr_src();

    // 3b: immediate masks the rs2 hazard
    bundle(5'd1, 5'd7, 5'd2, 5'd8);
    in_use_imm = 2'b01; in_imm = {32'h0, 32'h9};
    set_src(1, 5'd7, 1'b0, 32'hBAD);
    issue("t3imm");
    chk("t3imm_op2", out_op2, {32'h1000_0008, 32'h9});
    chk("t3imm_stall_cnt", stall_cnt, 3);
    tick(); clr_src(); in_use_imm = '0; in_imm = '0;

    // 4: branches (all tied low when branch logic is compiled out)
    bundle(5'd10, 5'd0, 5'd0, 5'd0);
    set_src(0, 5'd10, 1'b1, 32'h8000_0000);
    in_br_op = 3'd6; in_pred_taken = 1'b1; in_br_target = 32'h1234; in_pred_target = 32'h1234;
    issue("t4gtz");
    chk("t4gtz_op1", out_op1, {32'h0, 32'h8000_0000});
    chk("t4gtz_br_valid", br_valid, BR_EN);
    chk("t4gtz_taken", br_taken, 0);
    chk("t4gtz_mispredict", br_mispredict, BR_EN);
    chk("t4gtz_target", br_target, BR_EN ? 32'h1234 : 32'h0);
    tick(); clr_src();

    bundle(5'd11, 5'd0, 5'd0, 5'd0);
    set_src(0, 5'd11, 1'b1, 32'h400);
    in_br_op = 3'd7; in_pred_taken = 1'b1; in_pred_target = 32'h400; in_br_target = 32'h9999;
    issue("t4jr");
    chk("t4jr_br_valid", br_valid, BR_EN);
    chk("t4jr_taken", br_taken, BR_EN);
    chk("t4jr_target", br_target, BR_EN ? 32'h400 : 32'h0);
    chk("t4jr_mispredict", br_mispredict, 0);
    tick(); clr_src();

    bundle(5'd12, 5'd12, 5'd0, 5'd0);
    in_br_op = 3'd1; in_pred_taken = 1'b0; in_br_target = 32'h2000; in_pred_target = 32'h0;
    issue("t4eq");
    chk("t4eq_taken", br_taken, BR_EN);
    chk("t4eq_mispredict", br_mispredict, BR_EN);
    chk("t4eq_target", br_target, BR_EN ? 32'h2000 : 32'h0);
    tick();
    in_br_op = '0; in_pred_taken = 1'b0; in_br_target = '0; in_pred_target = '0;

    // 5: back-pressure with a second bundle waiting
    out_ready = 1'b0;
    bundle(5'd13, 5'd0, 5'd0, 5'd0);
    in_valid = 1'b1;
    mid(); chk("t5_in_ready_a", in_ready, 1);
    tick();
    bundle(5'd14, 5'd0, 5'd0, 5'd0);
    mid(); chk("t5_in_ready_capt", in_ready, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("t5_hold_valid", out_valid, 1);
      chk("t5_hold_in_ready", in_ready, 0);
      chk("t5_hold_op1", out_op1, {32'h0, 32'h1000_000D});
      tick();
    end
    out_ready = 1'b1;
    mid();
    chk("t5_release_in_ready", in_ready, 1);
    chk("t5_release_op1", out_op1, {32'h0, 32'h1000_000D});
    tick(); in_valid = 1'b0;
    mid(); chk("t5_b_capt", out_valid, 0);
    tick();
    mid();
    chk("t5_b_valid", out_valid, 1);
    chk("t5_b_op1", out_op1, {32'h0, 32'h1000_000E});
    tick();

    // 6: flush during WAIT drops the offered bundle and keeps stall_cnt
    bundle(5'd15, 5'd0, 5'd0, 5'd0);
    set_src(0, 5'd15, 1'b0, 32'h0);
    in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    mid(); chk("t6_wait", out_valid, 0);
    tick();
    flush = 1'b1; in_valid = 1'b1;
    bundle(5'd16, 5'd0, 5'd0, 5'd0);
    clr_src();
    mid(); chk("t6_flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    mid();
    chk("t6_empty_valid", out_valid, 0);
    chk("t6_empty_in_ready", in_ready, 1);
    chk("t6_stall_kept", stall_cnt, 4);
    tick();
    mid(); chk("t6_not_accepted", out_valid, 0);

    // 6b: reset in the middle of a stall
    tick();
    bundle(5'd15, 5'd0, 5'd0, 5'd0);
    set_src(0, 5'd15, 1'b0, 32'h0);
    in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tick();
    mid(); chk("t6r_cnt_before", stall_cnt, 5);
    rst_n = 1'b0;
    tick();
    mid();
    chk("t6r_out_valid", out_valid, 0);
    chk("t6r_in_ready", in_ready, 0);
    chk("t6r_stall_cnt", stall_cnt, 0);
    chk("t6r_op1", out_op1, 0);
    chk("t6r_op2", out_op2, 0);
    chk("t6r_br_valid", br_valid, 0);
    chk("t6r_br_taken", br_taken, 0);
    chk("t6r_br_mispredict", br_mispredict, 0);
    chk("t6r_br_target", br_target, 0);
    rst_n = 1'b1;
    clr_src();
    tick();
    mid();
    chk("t6r_bundle_lost", out_valid, 0);
    chk("t6r_in_ready_after", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
